// File: rtl/apb_rdc_pkg.sv
// apb_rdc_pkg: register map, ID constant, STATUS/CTRL bit positions and the
// DATA-read wait-state FSM encoding shared by the resolver sample slave.
package apb_rdc_pkg;

   localparam logic [7:0]  ADDR_CTRL   = 8'h00;
   localparam logic [7:0]  ADDR_STATUS = 8'h04;
   localparam logic [7:0]  ADDR_DATA   = 8'h08;
   localparam logic [7:0]  ADDR_THRESH = 8'h0C;
   localparam logic [7:0]  ADDR_ID     = 8'h10;

   localparam logic [31:0] RDC_ID      = 32'h5244_4301;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;
   localparam int STAT_EMPTY_BIT = 9;
   localparam int STAT_FULL_BIT  = 10;
   localparam int STAT_OVF_BIT   = 11;
   localparam int THRESH_W       = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } rd_state_e;

   // Assemble the STATUS read word from its fields
   function automatic logic [31:0] pack_status(input logic [8:0] count,
                                               input logic       empty,
                                               input logic       full,
                                               input logic       ovf);
      logic [31:0] w;
      w                 = 32'd0;
      w[8:0]            = count;
      w[STAT_EMPTY_BIT] = empty;
      w[STAT_FULL_BIT]  = full;
      w[STAT_OVF_BIT]   = ovf;
      return w;
   endfunction

endpackage

// File: rtl/apb_rdc_slave_fifo.sv
// rdc_sync_fifo: single-clock sample FIFO with flush; a pop frees a slot for a
// push in the same cycle, and flush overrides both.
module rdc_sync_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        flush,
   input  logic [DATA_W-1:0]           din,
   output logic [DATA_W-1:0]           dout,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              do_push_s;
   logic              do_pop_s;

   assign full      = (count_r == CW'(FIFO_DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign do_pop_s  = pop & ~flush & ~empty;
   assign do_push_s = push & ~flush & (~full | do_pop_s);

   // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sample storage write port
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/apb_rdc_slave.sv
// apb_rdc_slave: APB3 slave buffering resolver angle samples for the EMPU.
// Optional macro APB_RDC_IRQ_EN adds the THRESH register and the level irq.
module apb_rdc_slave
   import apb_rdc_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 16
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [7:0]        paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic              smp_valid,
   input  logic [DATA_W-1:0] smp_data,
   output logic              irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rd_state_e            state_r, state_s;
   logic                 en_r, ovf_r, data_vld_r;
   logic [31:0]          data_r;
   logic                 access_s, bad_s, capture_s, pop_s, wr_en_s;
   logic                 pready_s, pslverr_s;
   logic [31:0]          prdata_s, rd_val_s, status_s;
   logic                 wr_ctrl_s, wr_stat_s, wr_thresh_s;
   logic                 push_s, flush_s, ovf_set_s, ovf_clr_s;
   logic [DATA_W-1:0]    fifo_dout_s;
   logic [CW-1:0]        count_s;
   logic [THRESH_W-1:0]  count9_s, thresh_s;
   logic                 full_s, empty_s;
   logic                 unused_ok_s;

   rdc_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk   (sys_clk),
      .rst_n (reset_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .din   (smp_data),
      .dout  (fifo_dout_s),
      .count (count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   assign access_s = psel & penable;
   assign count9_s = THRESH_W'(count_s);
   assign status_s = pack_status(count9_s, empty_s, full_s, ovf_r);

   // Address decode: read value and error classification of the current transfer
   always_comb begin
      rd_val_s = 32'd0;
      bad_s    = 1'b0;
      case (paddr)
         ADDR_CTRL:   rd_val_s = {31'd0, en_r};
         ADDR_STATUS: begin
            rd_val_s = status_s;
            bad_s    = pwrite & ~pwdata[STAT_OVF_BIT];
         end
         ADDR_DATA:   bad_s = pwrite;
         ADDR_THRESH: rd_val_s = {23'd0, thresh_s};
         ADDR_ID:     begin
            rd_val_s = RDC_ID;
            bad_s    = pwrite;
         end
         default:     bad_s = 1'b1;
      endcase
   end

   // Wait-state FSM: only DATA reads stall, so the FIFO head can be registered
   always_comb begin
      state_s   = IDLE;
      pready_s  = 1'b1;
      pslverr_s = 1'b0;
      prdata_s  = 32'd0;
      capture_s = 1'b0;
      pop_s     = 1'b0;
      wr_en_s   = 1'b0;
      case (state_r)
         WAIT: begin
            if (access_s) begin
               prdata_s = data_r;
               pop_s    = data_vld_r;
               state_s  = DONE;
            end else begin
               state_s  = IDLE;
            end
         end
         IDLE, DONE: begin
            if (access_s && !pwrite && (paddr == ADDR_DATA)) begin
               pready_s  = 1'b0;
               capture_s = 1'b1;
               state_s   = WAIT;
            end else if (access_s) begin
               pslverr_s = bad_s;
               wr_en_s   = pwrite & ~bad_s;
               prdata_s  = (pwrite | bad_s) ? 32'd0 : rd_val_s;
               state_s   = IDLE;
            end else begin
               state_s   = IDLE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   assign pready  = pready_s;
   assign pslverr = pslverr_s;
   assign prdata  = prdata_s;

   assign wr_ctrl_s   = wr_en_s & (paddr == ADDR_CTRL);
   assign wr_stat_s   = wr_en_s & (paddr == ADDR_STATUS);
   assign wr_thresh_s = wr_en_s & (paddr == ADDR_THRESH);
   assign flush_s     = wr_ctrl_s & pwdata[CTRL_FLUSH_BIT];
   assign ovf_clr_s   = wr_stat_s & pwdata[STAT_OVF_BIT];
   assign push_s      = en_r & smp_valid;
   // A push at full only overflows when no pop frees a slot this cycle
   assign ovf_set_s   = push_s & full_s & ~pop_s & ~flush_s;

   // Control, sticky overflow and captured FIFO head
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         en_r       <= 1'b0;
         ovf_r      <= 1'b0;
         data_r     <= 32'd0;
         data_vld_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (wr_ctrl_s) en_r <= pwdata[CTRL_EN_BIT];
         if (ovf_set_s)      ovf_r <= 1'b1;
         else if (ovf_clr_s) ovf_r <= 1'b0;
         if (capture_s) begin
            data_r     <= empty_s ? 32'd0 : 32'(fifo_dout_s);
            data_vld_r <= ~empty_s;
         end
      end
   end

`ifdef APB_RDC_IRQ_EN
   logic [THRESH_W-1:0] thresh_r;
   logic                irq_r;

   // Threshold register and registered level interrupt
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         thresh_r <= {THRESH_W{1'b0}};
         irq_r    <= 1'b0;
      end else begin
         if (wr_thresh_s) thresh_r <= pwdata[THRESH_W-1:0];
         irq_r <= en_r & (((thresh_r != {THRESH_W{1'b0}}) & (count9_s >= thresh_r)) | ovf_r);
      end
   end

   assign thresh_s = thresh_r;
   assign irq      = irq_r;
`else
   assign thresh_s = {THRESH_W{1'b0}};
   assign irq      = 1'b0;
`endif

   assign unused_ok_s = ^{pwdata[31:12], pwdata[10:2], wr_thresh_s};

endmodule

// File: tb/tb_apb_rdc_slave.sv
// tb_apb_rdc_slave: vector table plus sample-queue scoreboard for apb_rdc_slave.
module tb_apb_rdc_slave;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = 8'h00;
   logic [31:0] pwdata = 32'd0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        smp_valid = 1'b0;
   logic [15:0] smp_data = 16'd0;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl_q[$];
   logic [31:0] sb_q[$];
   logic        mdl_en  = 1'b0;
   logic        mdl_ovf = 1'b0;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_waits;
   } vec_t;

   vec_t vecs[16];

   apb_rdc_slave #(.FIFO_DEPTH(16), .DATA_W(16)) dut (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .irq       (irq)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] w;
      w        = 32'd0;
      w[8:0]   = 9'(mdl_q.size());
      w[9]     = (mdl_q.size() == 0);
      w[10]    = (mdl_q.size() == 16);
      w[11]    = mdl_ovf;
      return w;
   endfunction

   function automatic void model_push(input logic [15:0] d);
      if (mdl_en) begin
         if (mdl_q.size() < 16) mdl_q.push_back({16'd0, d});
         else                   mdl_ovf = 1'b1;
      end
   endfunction

   // One APB transfer; sv/sd are presented as a sample in the completing cycle
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic sv, input logic [15:0] sd,
                           output logic [31:0] rd, output logic err, output int waits);
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      waits = 0; rd = 32'd0; err = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (pready) begin
            rd = prdata; err = pslverr;
            smp_valid = sv; smp_data = sd;
            break;
         end
         waits++;
         if (waits > 8) begin
            n_tests++; n_fail++;
            $display("FAIL apb_timeout: addr 0x%02h got no pready, expected it within 8 cycles", addr);
            break;
         end
      end
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; smp_valid = 1'b0;
   endtask

   task automatic push_smp(input logic [15:0] d);
      @(posedge sys_clk); #1;
      smp_valid = 1'b1; smp_data = d;
      @(posedge sys_clk); #1;
      smp_valid = 1'b0;
      model_push(d);
   endtask

   task automatic rd_data(input string nm, input logic sv, input logic [15:0] sd);
      logic [31:0] exp, rd;
      logic        err, had;
      int          w;
      had = (mdl_q.size() != 0);
      exp = had ? mdl_q[0] : 32'd0;
      apb_xfer(1'b0, 8'h08, 32'd0, sv, sd, rd, err, w);
      check({nm, "_data"}, rd, exp);
      check({nm, "_err"}, 32'(err), 32'd0);
      check({nm, "_waits"}, 32'(w), 32'd1);
      if (had) void'(mdl_q.pop_front());
      if (sv) model_push(sd);
   endtask

   task automatic chk_status(input string nm);
      logic [31:0] rd;
      logic        err;
      int          w;
      apb_xfer(1'b0, 8'h04, 32'd0, 1'b0, 16'd0, rd, err, w);
      check(nm, rd, exp_status());
   endtask

   task automatic wr_reg(input string nm, input logic [7:0] a, input logic [31:0] d, input logic sv, input logic [15:0] sd);
      logic [31:0] rd;
      logic        err;
      int          w;
      apb_xfer(1'b1, a, d, sv, sd, rd, err, w);
      check({nm, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic rd_reg(input string nm, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        err;
      int          w;
      apb_xfer(1'b0, a, 32'd0, 1'b0, 16'd0, rd, err, w);
      check(nm, rd, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          w;

      vecs[0]  = '{1'b1, 8'h00, 32'h1,    32'h0,          1'b0, 0};
      vecs[1]  = '{1'b0, 8'h10, 32'h0,    32'h5244_4301,  1'b0, 0};
      vecs[2]  = '{1'b0, 8'h00, 32'h0,    32'h1,          1'b0, 0};
      vecs[3]  = '{1'b0, 8'h04, 32'h0,    32'h200,        1'b0, 0};
      vecs[4]  = '{1'b0, 8'h14, 32'h0,    32'h0,          1'b1, 0};
      vecs[5]  = '{1'b1, 8'h04, 32'h1,    32'h0,          1'b1, 0};
      vecs[6]  = '{1'b0, 8'h02, 32'h0,    32'h0,          1'b1, 0};
      vecs[7]  = '{1'b1, 8'h10, 32'h0,    32'h0,          1'b1, 0};
      vecs[8]  = '{1'b1, 8'h08, 32'h1234, 32'h0,          1'b1, 0};
      vecs[9]  = '{1'b0, 8'h00, 32'h0,    32'h1,          1'b0, 0};
      vecs[10] = '{1'b0, 8'h04, 32'h0,    32'h200,        1'b0, 0};
      vecs[11] = '{1'b1, 8'h0C, 32'h5,    32'h0,          1'b0, 0};
`ifdef APB_RDC_IRQ_EN
      vecs[12] = '{1'b0, 8'h0C, 32'h0,    32'h5,          1'b0, 0};
`else
      vecs[12] = '{1'b0, 8'h0C, 32'h0,    32'h0,          1'b0, 0};
`endif
      vecs[13] = '{1'b0, 8'h08, 32'h0,    32'h0,          1'b0, 1};
      vecs[14] = '{1'b1, 8'h00, 32'h3,    32'h0,          1'b0, 0};
      vecs[15] = '{1'b0, 8'h00, 32'h0,    32'h1,          1'b0, 0};

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_pready", 32'(pready), 32'd1);
      check("rst_pslverr", 32'(pslverr), 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      @(negedge sys_clk);
      reset_n = 1'b1;

      // Register map and error responses
      for (int i = 0; i < 16; i++) begin
         if (!vecs[i].wr) sb_q.push_back(vecs[i].exp_rd);
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, 1'b0, 16'd0, rd, err, w);
         if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, sb_q.pop_front());
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
      end
      mdl_en = 1'b1;

      // Three samples read back in order
      push_smp(16'h1111);
      push_smp(16'h2222);
      push_smp(16'h3333);
      for (int i = 0; i < 3; i++) rd_data($sformatf("fifo3_%0d", i), 1'b0, 16'd0);
      chk_status("fifo3_status");

      // Overflow at full, then W1C
      for (int i = 0; i < 17; i++) push_smp(16'h0100 + 16'(i));
      chk_status("ovf_status");
`ifdef APB_RDC_IRQ_EN
      check("ovf_irq", 32'(irq), 32'd1);
`else
      check("ovf_irq", 32'(irq), 32'd0);
`endif
      wr_reg("w1c", 8'h04, 32'h800, 1'b0, 16'd0);
      mdl_ovf = 1'b0;
      chk_status("w1c_status");

      // Pop and push in the same cycle at full
      rd_data("full_poppush", 1'b1, 16'hABCD);
      chk_status("full_poppush_status");
      for (int i = 0; i < 16; i++) rd_data($sformatf("drain%0d", i), 1'b0, 16'd0);
      chk_status("drain_status");

      // Flush discards the FIFO and a coincident push
      push_smp(16'h0A0A);
      push_smp(16'h0B0B);
      wr_reg("flush", 8'h00, 32'h3, 1'b1, 16'h5555);
      mdl_q.delete();
      chk_status("flush_status");
      rd_reg("flush_ctrl", 8'h00, 32'h1);

      // Disabled capture drops samples
      wr_reg("dis", 8'h00, 32'h0, 1'b0, 16'd0);
      mdl_en = 1'b0;
      push_smp(16'h7777);
      chk_status("dis_status");
      wr_reg("ena", 8'h00, 32'h1, 1'b0, 16'd0);
      mdl_en = 1'b1;

      // Empty DATA read with a coincident push
      rd_data("empty_push", 1'b1, 16'h4242);
      chk_status("empty_push_status");
      rd_data("after_empty_push", 1'b0, 16'd0);

`ifdef APB_RDC_IRQ_EN
      // Threshold interrupt
      wr_reg("thresh4", 8'h0C, 32'h4, 1'b0, 16'd0);
      for (int i = 0; i < 4; i++) push_smp(16'h0C00 + 16'(i));
      check("irq_same_cycle", 32'(irq), 32'd0);
      @(posedge sys_clk); #1;
      check("irq_next_cycle", 32'(irq), 32'd1);
      rd_data("irq_pop", 1'b0, 16'd0);
      @(posedge sys_clk); #1;
      check("irq_after_pop", 32'(irq), 32'd0);
      for (int i = 0; i < 3; i++) rd_data($sformatf("irq_drain%0d", i), 1'b0, 16'd0);
`endif

      // Reset in the middle of a DATA read
      push_smp(16'h0D01);
      push_smp(16'h0D02);
      @(posedge sys_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      @(negedge sys_clk);
      check("abort_first_wait", 32'(pready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("abort_prdata", prdata, 32'd0);
      check("abort_irq", 32'(irq), 32'd0);
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge sys_clk);
      reset_n = 1'b1;
      mdl_q.delete();
      mdl_en  = 1'b0;
      mdl_ovf = 1'b0;
      chk_status("abort_status");
      rd_reg("abort_ctrl", 8'h00, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
